alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 23 ++
 rtl/alu_arbiter_rr_arb2.sv | 29 ++
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU front end: opcodes, FSM encoding
// and the default datapath width.
package alu_arbiter_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    // Pick the winner from the valid vector and the last-grant pointer.
    always_comb begin
        gnt_idx_o = 1'b0;
        gnt_vld_o = 1'b0;
        if (valid_i == 2'b11) begin
            gnt_idx_o = ~last_i;
            gnt_vld_o = 1'b1;
        end else if (valid_i[0]) begin
            gnt_idx_o = 1'b0;
            gnt_vld_o = 1'b1;
        end else if (valid_i[1]) begin
            gnt_idx_o = 1'b1;
            gnt_vld_o = 1'b1;
        end else begin
            gnt_idx_o = 1'b0;
            gnt_vld_o = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto an external registered ALU, one operation in
// flight, and returns the captured result through a valid/ready response port.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_opco,
    input  logic [WIDTH-1:0] req0_o1,
    input  logic [WIDTH-1:0] req0_o2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_opco,
    input  logic [WIDTH-1:0] req1_o1,
    input  logic [WIDTH-1:0] req1_o2,
    output logic [WIDTH-1:0] alu_o1,
    output logic [WIDTH-1:0] alu_o2,
    output logic [2:0]       alu_opco,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_sign,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_sign,
    output logic             rsp_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] alu_o1_q, alu_o1_d, alu_o2_q, alu_o2_d;
    logic [2:0]       alu_opco_q, alu_opco_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic             busy_q, busy_d;

    logic             gnt_idx_s, gnt_vld_s, accept_s;
    logic [2:0]       sel_opco_s;
    logic [WIDTH-1:0] sel_o1_s, sel_o2_s;

    rr_arb2 u_rr_arb2 (
        .valid_i   ({req1_valid, req0_valid}),
        .last_i    (last_q),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    assign accept_s   = (state_q == ST_IDLE) && gnt_vld_s;
    assign req0_ready = accept_s && !gnt_idx_s;
    assign req1_ready = accept_s && gnt_idx_s;

    // Route the granted requester's operation toward the ALU registers.
    always_comb begin
        sel_opco_s = req0_opco;
        sel_o1_s   = req0_o1;
        sel_o2_s   = req0_o2;
        if (gnt_idx_s) begin
            sel_opco_s = req1_opco;
            sel_o1_s   = req1_o1;
            sel_o2_s   = req1_o2;
        end else begin
            sel_opco_s = req0_opco;
            sel_o1_s   = req0_o1;
            sel_o2_s   = req0_o2;
        end
    end

    // Next-state and datapath load decisions for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        alu_o1_d     = alu_o1_q;
        alu_o2_d     = alu_o2_q;
        alu_opco_d   = alu_opco_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    last_d   = gnt_idx_s;
                    rsp_id_d = gnt_idx_s;
                    if (sel_opco_s != OP_NOP) begin
                        alu_o1_d   = sel_o1_s;
                        alu_o2_d   = sel_o2_s;
                        alu_opco_d = sel_opco_s;
                        state_d    = ST_EXEC;
                    end else begin
                        // A nop never reaches the ALU; answer with an all-zero response.
                        rsp_result_d = {WIDTH{1'b0}};
                        rsp_flags_d  = 3'b000;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                alu_opco_d = OP_NOP;
                state_d    = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {alu_carry, alu_sign, alu_zero};
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            alu_o1_q     <= {WIDTH{1'b0}};
            alu_o2_q     <= {WIDTH{1'b0}};
            alu_opco_q   <= OP_NOP;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_flags_q  <= 3'b000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            alu_o1_q     <= alu_o1_d;
            alu_o2_q     <= alu_o2_d;
            alu_opco_q   <= alu_opco_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_o1     = alu_o1_q;
    assign alu_o2     = alu_o2_q;
    assign alu_opco   = alu_opco_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_flags_q[2];
    assign rsp_sign   = rsp_flags_q[1];
    assign rsp_zero   = rsp_flags_q[0];
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in registered ALU plus a transaction-level
// reference for grant order, latency and response contents.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_opco, req1_opco, alu_opco;
    logic [7:0] req0_o1, req0_o2, req1_o1, req1_o2, alu_o1, alu_o2;
    logic [7:0] alu_result, rsp_result;
    logic       alu_carry, alu_sign, alu_zero;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_sign, rsp_zero, busy;

    int   total = 0;
    int   bad   = 0;
    logic ptr;
    logic w_unused;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opco(req0_opco),
        .req0_o1(req0_o1), .req0_o2(req0_o2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opco(req1_opco),
        .req1_o1(req1_o1), .req1_o2(req1_o2),
        .alu_o1(alu_o1), .alu_o2(alu_o2), .alu_opco(alu_opco),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_sign(rsp_sign), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    // Returns {carry, sign, zero, result}; carry on sub is the borrow.
    function automatic logic [10:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        case (op)
            3'b001:  t = {1'b0, a} + {1'b0, b};
            3'b010:  t = {1'b0, a} - {1'b0, b};
            3'b011:  t = {1'b0, a & b};
            3'b100:  t = {1'b0, a | b};
            3'b101:  t = {1'b0, a ^ b};
            3'b110:  t = {1'b0, ~(a ^ b)};
            3'b111:  t = {1'b0, b};
            default: t = 9'd0;
        endcase
        if (op == 3'b000) return 11'd0;
        return {t[8], t[7], (t[7:0] == 8'd0), t[7:0]};
    endfunction

    // Stand-in for the team ALU: registered, holds its result on nop.
    logic [10:0] alu_pack;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_pack <= 11'd0;
        else if (alu_opco != 3'b000) alu_pack <= ref_alu(alu_opco, alu_o1, alu_o2);
    end
    assign {alu_carry, alu_sign, alu_zero, alu_result} = alu_pack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_alu"}, {8'd0, alu_opco, 5'd0, alu_o1, alu_o2}, 32'd0);
        chk({tag, "_rsp"}, {20'd0, rsp_id, rsp_carry, rsp_sign, rsp_zero, rsp_result}, 32'd0);
    endtask

    // One complete transaction from presentation to response handshake.
    task automatic txn(input logic v0, input logic v1,
                       input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                       input int stall, output logic w);
        logic [2:0]  op;
        logic [7:0]  a, b, o1_before, o2_before;
        logic [10:0] e;
        int          lat;
        bit          done;
        req0_valid = v0; req0_opco = op0; req0_o1 = a0; req0_o2 = b0;
        req1_valid = v1; req1_opco = op1; req1_o1 = a1; req1_o2 = b1;
        #1;
        w = (v0 && v1) ? ~ptr : !v0;
        chk("grant_req0", 32'(req0_ready), 32'(w == 1'b0));
        chk("grant_req1", 32'(req1_ready), 32'(w == 1'b1));
        op = w ? op1 : op0;
        a  = w ? a1 : a0;
        b  = w ? b1 : b0;
        e  = ref_alu(op, a, b);
        o1_before = alu_o1;
        o2_before = alu_o2;
        @(posedge clk);
        ptr = w;
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_o1 = 8'($urandom); req1_o2 = 8'($urandom); req0_opco = 3'($urandom);
        lat = 0; done = 1'b0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (op == 3'b000) chk("nop_alu_opco", 32'(alu_opco), 32'd0);
            else if (lat == 1) chk("issue", {13'd0, alu_opco, alu_o1, alu_o2}, {13'd0, op, a, b});
            else if (lat == 2) chk("opco_cleared", 32'(alu_opco), 32'd0);
            if (rsp_valid) done = 1'b1;
        end
        chk("latency", 32'(lat), (op == 3'b000) ? 32'd1 : 32'd3);
        if (op == 3'b000) chk("nop_alu_held", {16'd0, alu_o1, alu_o2}, {16'd0, o1_before, o2_before});
        chk("rsp_data", {21'd0, rsp_carry, rsp_sign, rsp_zero, rsp_result}, {21'd0, e});
        chk("rsp_id", 32'(rsp_id), 32'(w));
        chk("busy_resp", 32'(busy), 32'd1);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            #1;
            chk("stall_no_grant", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("stall_hold", {20'd0, rsp_valid, rsp_id, rsp_carry, rsp_sign, rsp_zero, rsp_result},
                {20'd0, 1'b1, w, e});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
        #1;
        chk("handshake_no_grant", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("after_handshake", {30'd0, rsp_valid, busy}, 32'd0);
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_opco = 3'd0; req0_o1 = 8'd0; req0_o2 = 8'd0;
        req1_valid = 1'b0; req1_opco = 3'd0; req1_o1 = 8'd0; req1_o2 = 8'd0;
        ptr = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters contending: grants must alternate starting with req0.
        for (int k = 0; k < 4; k++) begin
            txn(1'b1, 1'b1, 3'b101, 8'hAA, 8'hAA, 3'b111, 8'h11, 8'h5C, 0, w_unused);
            chk("alternate", 32'(w_unused), 32'(k % 2));
        end

        txn(1'b1, 1'b0, 3'b001, 8'hF0, 8'h20, 3'b000, 8'h00, 8'h00, 0, w_unused);
        chk("add_result", {23'd0, rsp_carry, rsp_result}, {23'd0, 1'b1, 8'h10});

        txn(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, 3'b010, 8'h03, 8'h05, 5, w_unused);
        txn(1'b1, 1'b0, 3'b000, 8'h33, 8'h44, 3'b000, 8'h00, 8'h00, 0, w_unused);

        // Reset pulsed while an add is in EXEC.
        req0_valid = 1'b1; req0_opco = 3'b001; req0_o1 = 8'h12; req0_o2 = 8'h34;
        #1;
        chk("pre_reset_accept", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        ptr = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b1, 3'b101, 8'hAA, 8'hAA, 3'b111, 8'h00, 8'h5C, 0, w_unused);
        chk("post_reset_req0_first", 32'(w_unused), 32'd0);

        for (int k = 0; k < 24; k++) begin
            int v;
            v = $urandom_range(1, 3);
            txn(1'(v), 1'(v >> 1), 3'($urandom), 8'($urandom), 8'($urandom),
                3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3), w_unused);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
